// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle integer ALU among NUM_REQ requesters, with a
// one-entry result register. Optional fire/stall counters are enabled by RVGA_ALU_ARB_STATS_EN.
//
// state | meaning
// EMPTY | no result held, res_v_o = 0
// FULL  | result, id and tag held in the output register, res_v_o = 1
//
// Op encoding (4-bit): 0 addsub, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srx, 6 or, 7 and, 8..15 undefined -> 0.

module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_v_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*4-1:0]     req_op_i,
    input  logic [NUM_REQ*32-1:0]    req_a_i,
    input  logic [NUM_REQ*32-1:0]    req_b_i,
    input  logic [NUM_REQ-1:0]       req_alt_i,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
    output logic                     res_v_o,
    input  logic                     res_ready_i,
    output logic [31:0]              res_o,
    output logic [ID_W-1:0]          res_id_o,
    output logic [TAG_W-1:0]         res_tag_o
`ifdef RVGA_ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]    stat_grant_o,
    output logic [31:0]              stat_stall_o
`endif
);

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADDSUB = 4'd0;
    localparam logic [OP_W-1:0] OP_SLL    = 4'd1;
    localparam logic [OP_W-1:0] OP_SLT    = 4'd2;
    localparam logic [OP_W-1:0] OP_SLTU   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR    = 4'd4;
    localparam logic [OP_W-1:0] OP_SRX    = 4'd5;
    localparam logic [OP_W-1:0] OP_OR     = 4'd6;
    localparam logic [OP_W-1:0] OP_AND    = 4'd7;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e          state_q;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] gnt;
    logic            any_v;
    logic            can_accept;
    logic            fire;

    logic [OP_W-1:0]  sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_alt;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      alu_res;

    function automatic logic [31:0] alu_eval(input logic [OP_W-1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic alt);
        logic [31:0] r;
        r = '0;
        case (op)
            OP_ADDSUB: r = alt ? (a - b) : (a + b);
            OP_SLL:    r = a << b[4:0];
            OP_SLT:    r = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU:   r = {31'b0, a < b};
            OP_XOR:    r = a ^ b;
            OP_SRX:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            OP_OR:     r = a | b;
            OP_AND:    r = a & b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Walk from farthest to nearest so the requester closest after last_q wins.
    always_comb begin
        gnt   = '0;
        any_v = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (req_v_i[cand]) begin
                gnt   = cand;
                any_v = 1'b1;
            end
        end
    end

    assign can_accept = (state_q == EMPTY) | res_ready_i;
    assign fire       = rst_n & any_v & can_accept;

    always_comb begin
        req_ready_o = '0;
        if (fire) begin
            req_ready_o[gnt] = 1'b1;
        end
    end

    assign sel_op  = req_op_i[int'(gnt)*OP_W +: OP_W];
    assign sel_a   = req_a_i[int'(gnt)*32 +: 32];
    assign sel_b   = req_b_i[int'(gnt)*32 +: 32];
    assign sel_alt = req_alt_i[gnt];
    assign sel_tag = req_tag_i[int'(gnt)*TAG_W +: TAG_W];
    assign alu_res = alu_eval(sel_op, sel_a, sel_b, sel_alt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            res_o     <= '0;
            res_id_o  <= '0;
            res_tag_o <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
        end else if (fire) begin
            state_q   <= FULL;
            res_o     <= alu_res;
            res_id_o  <= gnt;
            res_tag_o <= sel_tag;
            last_q    <= gnt;
        end else if (res_ready_i) begin
            state_q   <= EMPTY;
        end
    end

    assign res_v_o = (state_q == FULL);

`ifdef RVGA_ALU_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (fire && (grant_cnt[gnt] != 32'hFFFF_FFFF)) begin
                grant_cnt[gnt] <= grant_cnt[gnt] + 32'd1;
            end
            if (any_v && !fire && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_grant_o[gi*32 +: 32] = grant_cnt[gi];
    end
    assign stat_stall_o = stall_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: hand-derived vector table, directed multi-cycle sequences
// and randomized traffic against a behavioural reference model.

module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_v;
    logic [N-1:0]    req_ready;
    logic [3:0]      op [N];
    logic [31:0]     a [N];
    logic [31:0]     b [N];
    logic [N-1:0]    alt;
    logic [TW-1:0]   tag [N];
    logic            rr;
    logic            res_v;
    logic [31:0]     res;
    logic            res_id;
    logic [TW-1:0]   res_tag;

    logic [N*4-1:0]  req_op;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*TW-1:0] req_tag;

`ifdef RVGA_ALU_ARB_STATS_EN
    logic [N*32-1:0] stat_grant;
    logic [31:0]     stat_stall;
`endif

    always_comb begin
        req_op  = '0;
        req_a   = '0;
        req_b   = '0;
        req_tag = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i*4 +: 4]    = op[i];
            req_a[i*32 +: 32]   = a[i];
            req_b[i*32 +: 32]   = b[i];
            req_tag[i*TW +: TW] = tag[i];
        end
    end

    alu_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_v_i     (req_v),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_alt_i   (alt),
        .req_tag_i   (req_tag),
        .res_v_o     (res_v),
        .res_ready_i (rr),
        .res_o       (res),
        .res_id_o    (res_id),
        .res_tag_o   (res_tag)
`ifdef RVGA_ALU_ARB_STATS_EN
        ,
        .stat_grant_o(stat_grant),
        .stat_stall_o(stat_stall)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU computed with plain arithmetic on the op semantics.
    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic s);
        int sh;
        logic [63:0] ext;
        sh  = int'(y[4:0]);
        ext = {{32{x[31]}}, x};
        case (o)
            4'd0:    return s ? x + (~y) + 32'd1 : x + y;
            4'd1:    return 32'(x * (64'd1 << sh));
            4'd2:    return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd3:    return (longint'({32'b0, x}) < longint'({32'b0, y})) ? 32'd1 : 32'd0;
            4'd4:    return x ^ y;
            4'd5:    return s ? 32'(ext >> sh) : 32'({32'b0, x} >> sh);
            4'd6:    return x | y;
            4'd7:    return x & y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    logic          m_v;
    logic [31:0]   m_res;
    int            m_id;
    logic [TW-1:0] m_tag;
    int            m_last;

    task automatic model_reset();
        m_v = 1'b0; m_res = '0; m_id = 0; m_tag = '0; m_last = N - 1;
    endtask

    // Entered at posedge+1 with inputs driven; leaves at the following posedge+1.
    task automatic model_cycle(output logic [N-1:0] rdy);
        int g;
        logic can;
        #1;
        can = !m_v || rr;
        g = pick(req_v, m_last);
        rdy = '0;
        if (g >= 0 && can) rdy = N'(1 << g);
        check("rnd_ready", req_ready, rdy);
        @(posedge clk); #1;
        if (rdy != '0) begin
            m_res = ref_alu(op[g], a[g], b[g], alt[g]);
            m_id = g; m_tag = tag[g]; m_v = 1'b1; m_last = g;
        end else if (rr) begin
            m_v = 1'b0;
        end
        check("rnd_res_v", res_v, m_v);
        check("rnd_res", res, m_res);
        check("rnd_res_id", res_id, m_id);
        check("rnd_res_tag", res_tag, m_tag);
    endtask

    task automatic do_reset();
        req_v = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom % 5)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000 | ($urandom % 16);
            3: return $urandom % 40;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  v;
        logic [3:0]  op0; logic [31:0] a0; logic [31:0] b0; logic alt0; logic [3:0] tag0;
        logic [3:0]  op1; logic [31:0] a1; logic [31:0] b1; logic alt1; logic [3:0] tag1;
        logic        rr;
        logic [1:0]  rdy;
        logic        ev;
        logic [31:0] eres;
        logic        eid;
        logic [3:0]  etag;
    } vec_t;

    vec_t tbl [17];
    logic [N-1:0] hold;
    logic [N-1:0] rdy_m;

    initial begin
        // Sequence from reset: last pointer starts at 1, so requester 0 leads.
        tbl[0]  = '{2'b01, 4'd0, 32'd5, 32'd7, 1'b0, 4'd3,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b1, 2'b01, 1'b1, 32'd12, 1'b0, 4'd3};
        tbl[1]  = '{2'b11, 4'd0, 32'd1, 32'd2, 1'b0, 4'd1,  4'd4, 32'hF0, 32'h0F, 1'b0, 4'd2,
                    1'b1, 2'b10, 1'b1, 32'hFF, 1'b1, 4'd2};
        tbl[2]  = '{2'b11, 4'd0, 32'd1, 32'd2, 1'b0, 4'd1,  4'd4, 32'hF0, 32'h0F, 1'b0, 4'd2,
                    1'b1, 2'b01, 1'b1, 32'd3, 1'b0, 4'd1};
        tbl[3]  = '{2'b11, 4'd0, 32'd1, 32'd2, 1'b0, 4'd1,  4'd4, 32'hF0, 32'h0F, 1'b0, 4'd2,
                    1'b1, 2'b10, 1'b1, 32'hFF, 1'b1, 4'd2};
        tbl[4]  = '{2'b11, 4'd0, 32'd1, 32'd2, 1'b0, 4'd1,  4'd4, 32'hF0, 32'h0F, 1'b0, 4'd2,
                    1'b1, 2'b01, 1'b1, 32'd3, 1'b0, 4'd1};
        tbl[5]  = '{2'b10, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0,  4'd5, 32'h8000_0000, 32'd4, 1'b1, 4'd5,
                    1'b1, 2'b10, 1'b1, 32'hF800_0000, 1'b1, 4'd5};
        tbl[6]  = '{2'b00, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b1, 2'b00, 1'b0, 32'hF800_0000, 1'b1, 4'd5};
        tbl[7]  = '{2'b00, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b0, 2'b00, 1'b0, 32'hF800_0000, 1'b1, 4'd5};
        tbl[8]  = '{2'b01, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd6,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b0, 2'b01, 1'b1, 32'd1, 1'b0, 4'd6};
        tbl[9]  = '{2'b11, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd6,  4'd1, 32'd1, 32'd31, 1'b0, 4'd8,
                    1'b0, 2'b00, 1'b1, 32'd1, 1'b0, 4'd6};
        tbl[10] = '{2'b11, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd6,  4'd1, 32'd1, 32'd31, 1'b0, 4'd8,
                    1'b1, 2'b10, 1'b1, 32'h8000_0000, 1'b1, 4'd8};
        tbl[11] = '{2'b11, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd6,  4'd1, 32'd1, 32'd31, 1'b0, 4'd8,
                    1'b1, 2'b01, 1'b1, 32'd1, 1'b0, 4'd6};
        tbl[12] = '{2'b01, 4'd9, 32'd5, 32'd5, 1'b0, 4'd9,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b1, 2'b01, 1'b1, 32'd0, 1'b0, 4'd9};
        tbl[13] = '{2'b01, 4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 4'd10,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b1, 2'b01, 1'b1, 32'h0F00_0F00, 1'b0, 4'd10};
        tbl[14] = '{2'b01, 4'd5, 32'h8000_0000, 32'd4, 1'b0, 4'd11,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b1, 2'b01, 1'b1, 32'h0800_0000, 1'b0, 4'd11};
        tbl[15] = '{2'b01, 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd12,  4'd0, 32'd0, 32'd0, 1'b0, 4'd0,
                    1'b1, 2'b01, 1'b1, 32'd0, 1'b0, 4'd12};
        tbl[16] = '{2'b10, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0,  4'd6, 32'h1200, 32'h0034, 1'b1, 4'd13,
                    1'b1, 2'b10, 1'b1, 32'h1234, 1'b1, 4'd13};

        req_v = '0; rr = 1'b0; alt = '0;
        for (int i = 0; i < N; i++) begin
            op[i] = '0; a[i] = '0; b[i] = '0; tag[i] = '0;
        end

        // Reset state, with requests pending during reset.
        repeat (2) @(posedge clk);
        #1;
        req_v = 2'b11; rr = 1'b1;
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_res_v", res_v, 1'b0);
        check("rst_res", res, 32'd0);
        check("rst_res_id", res_id, 1'b0);
        check("rst_res_tag", res_tag, 4'd0);
        req_v = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 17; r++) begin
            req_v = tbl[r].v; rr = tbl[r].rr;
            op[0] = tbl[r].op0; a[0] = tbl[r].a0; b[0] = tbl[r].b0; alt[0] = tbl[r].alt0; tag[0] = tbl[r].tag0;
            op[1] = tbl[r].op1; a[1] = tbl[r].a1; b[1] = tbl[r].b1; alt[1] = tbl[r].alt1; tag[1] = tbl[r].tag1;
            #1;
            check($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_res_v", r), res_v, tbl[r].ev);
            check($sformatf("tbl%0d_res", r), res, tbl[r].eres);
            check($sformatf("tbl%0d_res_id", r), res_id, tbl[r].eid);
            check($sformatf("tbl%0d_res_tag", r), res_tag, tbl[r].etag);
        end

        // Backpressure: 3 - 5 held while the consumer stalls for 3 cycles.
        do_reset();
        op[0] = 4'd0; a[0] = 32'd3; b[0] = 32'd5; alt[0] = 1'b1; tag[0] = 4'd4;
        req_v = 2'b01; rr = 1'b1;
        #1;
        check("bp_first_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        check("bp_first_res", res, 32'hFFFF_FFFE);
        rr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_stall_ready", req_ready, 2'b00);
            @(posedge clk); #1;
            check("bp_stall_res_v", res_v, 1'b1);
            check("bp_stall_res", res, 32'hFFFF_FFFE);
            check("bp_stall_res_tag", res_tag, 4'd4);
        end
        rr = 1'b1;
        #1;
        check("bp_resume_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        check("bp_resume_res_v", res_v, 1'b1);
        check("bp_resume_res_id", res_id, 1'b0);

        // Async reset while FULL with requests pending, then round robin from a fresh pointer.
        op[1] = 4'd0; a[1] = 32'd9; b[1] = 32'd1; alt[1] = 1'b0; tag[1] = 4'd2;
        tag[0] = 4'd1;
        req_v = 2'b11; rr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_res_v", res_v, 1'b0);
        check("midrst_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1; rr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
            check("rr_res_id", res_id, k % 2);
            check("rr_res_tag", res_tag, (k % 2 == 0) ? 4'd1 : 4'd2);
            check("rr_res", res, (k % 2 == 0) ? 32'hFFFF_FFFE : 32'd10);
        end

`ifdef RVGA_ALU_ARB_STATS_EN
        do_reset();
        req_v = 2'b11; rr = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stat_grant", stat_grant, {32'd3, 32'd3});
        check("stat_stall", stat_stall, 32'd2);
`endif

        // Randomized traffic against the reference model, honouring the hold-while-pending rule.
        do_reset();
        model_reset();
        hold = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i]) begin
                    if ($urandom % 8 == 0) req_v[i] = 1'b0;
                end else begin
                    req_v[i] = ($urandom % 4) != 0;
                    op[i]    = 4'($urandom % 10);
                    a[i]     = rnd_word();
                    b[i]     = rnd_word();
                    alt[i]   = 1'($urandom % 2);
                    tag[i]   = 4'($urandom % 16);
                end
            end
            rr = ($urandom % 4) != 0;
            model_cycle(rdy_m);
            hold = req_v & ~rdy_m;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
